multicycle_main_control: RTL and testbench

Multicycle main control unit for the MIPS-subset CPU. It consumes the 6-bit instruction opcode and sequences fetch/decode/execute/memory/writeback through a Moore state machine. It drives every datapath strobe and mux select, including the 2-bit `alu_op` consumed by `ALU_CONTROL`, so it is the producing end of the ALUOp interface. It sits between the instruction register and the datapath.

---
 rtl/mc_ctrl_pkg.sv | 40 ++++
 rtl/mc_output_decode.sv | 109 ++++++++++
 rtl/multicycle_main_control.sv | 95 +++++++++
 tb/tb_multicycle_main_control.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle main control unit.
// State codes, opcodes, ALUOp and mux-select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: state (+zero for pc_en) to datapath strobes.
// Optional ADDI states built only with MC_ADDI_EN defined.
module mc_output_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     st,
  input  logic       rst_n,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       instr_done
);

  // Per-state strobes; everything held low while reset is asserted.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    if (rst_n) begin
      case (st)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMMSH;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
        end
`ifdef MC_ADDI_EN
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS-subset main control: state register + next state.
// Define MC_ADDI_EN to build the ADDIEX/ADDIWB path for addi.
module multicycle_main_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [3:0]       state
);

  state_t state_q;
  state_t state_d;
  logic   illegal_d;

  // State register with synchronous active-low reset to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next state; opcode only matters in DECODE and MEMADR.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_EXEC;
          OP_LW:    state_d = S_MEMADR;
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:  state_d = S_ADDIEX;
`endif
          default:  illegal_d = 1'b1;
        endcase
      end
      S_MEMADR:
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
`ifdef MC_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  assign illegal_op = illegal_d & rst_n;
  assign state      = state_q;

  mc_output_decode u_dec (
    .st            (state_q),
    .rst_n         (rst_n),
    .zero          (zero),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_en         (pc_en),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .instr_done    (instr_done)
  );

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control.
// Output vector checked against hand-written per-state constants.
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_write, pc_write_cond, pc_en, i_or_d;
  logic       mem_read, mem_write, ir_write, reg_write;
  logic       mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int compared;
  int mismatched;

  // {pc_write,pc_write_cond,pc_en,i_or_d,mem_read,mem_write,ir_write,
  //  reg_write,mem_to_reg,reg_dst,alu_src_a,alu_src_b,pc_source,
  //  alu_op,instr_done,illegal_op}
  localparam logic [18:0] V_ZERO  = 19'b0;
  localparam logic [18:0] V_FETCH = 19'b1_0_1_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] V_DEC   = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [18:0] V_DECIL = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [18:0] V_MADR  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] V_MRD   = 19'b0_0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] V_MWB   = 19'b0_0_0_0_0_0_0_1_1_0_0_00_00_00_1_0;
  localparam logic [18:0] V_MWR   = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [18:0] V_EXEC  = 19'b0_0_0_0_0_0_0_0_0_0_1_00_00_10_0_0;
  localparam logic [18:0] V_ALUWB = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [18:0] V_BRT   = 19'b0_1_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [18:0] V_BRN   = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [18:0] V_JUMP  = 19'b1_0_1_0_0_0_0_0_0_0_0_00_10_00_1_0;
  localparam logic [18:0] V_AIEX  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] V_AIWB  = 19'b0_0_0_0_0_0_0_1_0_0_0_00_00_00_1_0;

  multicycle_main_control #(.OPC_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_en         (pc_en),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] outs();
    return {pc_write, pc_write_cond, pc_en, i_or_d, mem_read,
            mem_write, ir_write, reg_write, mem_to_reg, reg_dst,
            alu_src_a, alu_src_b, pc_source, alu_op,
            instr_done, illegal_op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] est,
                     input logic [18:0] ev);
    logic [18:0] o;
    o = outs();
    compared++;
    assert (state === est) else begin
      mismatched++;
      $error("FAIL %s state: got %0d want %0d", tag, state, est);
    end
    compared++;
    assert (o === ev) else begin
      mismatched++;
      $error("FAIL %s outs: got %b want %b", tag, o, ev);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n  = 1'b0;
    opcode = 6'b100011;
    zero   = 1'b0;
    step();
    step();
    chk("reset", 4'd0, V_ZERO);

    // lw: 0,1,2,3,4
    rst_n = 1'b1;
    opcode = 6'b100011;
    #1;
    chk("lw_f", 4'd0, V_FETCH);
    step(); chk("lw_d", 4'd1, V_DEC);
    step(); chk("lw_ma", 4'd2, V_MADR);
    step(); chk("lw_mr", 4'd3, V_MRD);
    step(); chk("lw_wb", 4'd4, V_MWB);
    step(); chk("lw_end", 4'd0, V_FETCH);

    // R-type: 0,1,6,7
    opcode = 6'b000000;
    step(); chk("r_d", 4'd1, V_DEC);
    step(); chk("r_ex", 4'd6, V_EXEC);
    step(); chk("r_wb", 4'd7, V_ALUWB);
    step(); chk("r_end", 4'd0, V_FETCH);

    // beq taken then not taken
    opcode = 6'b000100;
    step(); chk("beq1_d", 4'd1, V_DEC);
    zero = 1'b1;
    step(); chk("beq1_br", 4'd8, V_BRT);
    step(); chk("beq1_end", 4'd0, V_FETCH);
    step(); chk("beq0_d", 4'd1, V_DEC);
    zero = 1'b0;
    step(); chk("beq0_br", 4'd8, V_BRN);
    step(); chk("beq0_end", 4'd0, V_FETCH);

    // illegal opcode
    opcode = 6'b111111;
    step(); chk("ill_d", 4'd1, V_DECIL);
    step(); chk("ill_end", 4'd0, V_FETCH);

    // addi
    opcode = 6'b001000;
`ifdef MC_ADDI_EN
    step(); chk("addi_d", 4'd1, V_DEC);
    step(); chk("addi_ex", 4'd10, V_AIEX);
    step(); chk("addi_wb", 4'd11, V_AIWB);
    step(); chk("addi_end", 4'd0, V_FETCH);
`else
    step(); chk("addi_d", 4'd1, V_DECIL);
    step(); chk("addi_end", 4'd0, V_FETCH);
`endif

    // reset during MEMRD
    opcode = 6'b100011;
    step(); chk("rlw_d", 4'd1, V_DEC);
    step(); chk("rlw_ma", 4'd2, V_MADR);
    step(); chk("rlw_mr", 4'd3, V_MRD);
    rst_n = 1'b0;
    #1;
    chk("rlw_rst", 4'd3, V_ZERO);
    step(); chk("rlw_abort", 4'd0, V_ZERO);
    rst_n = 1'b1;
    opcode = 6'b101011;
    #1;
    chk("rlw_rel", 4'd0, V_FETCH);

    // sw, j, sw back to back
    step(); chk("sw1_d", 4'd1, V_DEC);
    step(); chk("sw1_ma", 4'd2, V_MADR);
    step(); chk("sw1_wr", 4'd5, V_MWR);
    step(); chk("sw1_end", 4'd0, V_FETCH);
    opcode = 6'b000010;
    step(); chk("j_d", 4'd1, V_DEC);
    step(); chk("j_j", 4'd9, V_JUMP);
    step(); chk("j_end", 4'd0, V_FETCH);
    opcode = 6'b101011;
    step(); chk("sw2_d", 4'd1, V_DEC);
    step(); chk("sw2_ma", 4'd2, V_MADR);
    step(); chk("sw2_wr", 4'd5, V_MWR);
    step(); chk("sw2_end", 4'd0, V_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
